hazard_unit: RTL and testbench

- Pipeline control counterpart to the ID/EX register. Generates its stall/flush controls and the forwarding selects for the EX operand muxes.
- Consumes the register identifiers the ID/EX register carries: rsE, rtE, and the destination resolved from rdE/rtE/jalE.
- Adds sequential tracking of the multi-cycle multiply/divide unit, so mfhi/mflo stalls until the hi/lo result is valid.

---
 rtl/hazard_unit.sv | 125 ++++++++++++
 tb/tb_hazard_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding control for the 5-stage pipeline, with MDU hi/lo tracking.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_events counters.
module hazard_unit #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] write_regE,
  input  logic [4:0] write_regM,
  input  logic [4:0] write_regW,
  input  logic       we_regE,
  input  logic       we_regM,
  input  logic       we_regW,
  input  logic       dm2_regE,
  input  logic       dm2_regM,
  input  logic       branchD,
  input  logic       pc_srcD,
  input  logic       jumpD,
  input  logic       hi_loE,
  input  logic       mf_hi_loD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       fwd_aD,
  output logic       fwd_bD,
  output logic [1:0] fwd_aE,
  output logic [1:0] fwd_bE,
  output logic       hilo_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LAT);

  logic [CNT_W-1:0] cnt;
  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;

  // $0 is hardwired, so it never creates a dependency
  function automatic logic hit(input logic [4:0] w,
                               input logic [4:0] r);
    return (w != 5'd0) && (w == r);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] r,
                                      input logic       wm,
                                      input logic [4:0] dm,
                                      input logic       ww,
                                      input logic [4:0] dw);
    if (wm && hit(dm, r))
      return 2'b10;
    else if (ww && hit(dw, r))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (hi_loE)
      cnt <= LAT;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign hilo_busy = (cnt != '0);

  always_comb begin
    lwstall = dm2_regE &&
      (hit(write_regE, rsD) || hit(write_regE, rtD));
    brstall = branchD &&
      ((we_regE &&
        (hit(write_regE, rsD) || hit(write_regE, rtD))) ||
       (dm2_regM &&
        (hit(write_regM, rsD) || hit(write_regM, rtD))));
    mdstall = mf_hi_loD && (hilo_busy || hi_loE);
    stall   = !rst && (lwstall || brstall || mdstall);
  end

  always_comb begin
    stallF = stall;
    stallD = stall;
    flushE = stall;
    flushD = !rst && (pc_srcD || jumpD) && !stall;
    fwd_aD = 1'b0;
    fwd_bD = 1'b0;
    fwd_aE = 2'b00;
    fwd_bE = 2'b00;
    if (!rst) begin
      fwd_aD = we_regM && hit(write_regM, rsD);
      fwd_bD = we_regM && hit(write_regM, rtD);
      fwd_aE = fsel(rsE, we_regM, write_regM,
                    we_regW, write_regW);
      fwd_bE = fsel(rtE, we_regM, write_regM,
                    we_regW, write_regW);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall)
        stall_cycles <= stall_cycles + 32'd1;
      if (flushD)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic
// checked against a rule-level reference model.
module tb_hazard_unit;

  localparam int LAT = 4;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] write_regE, write_regM, write_regW;
  logic       we_regE, we_regM, we_regW;
  logic       dm2_regE, dm2_regM;
  logic       branchD, pc_srcD, jumpD;
  logic       hi_loE, mf_hi_loD;
  logic       stallF, stallD, flushD, flushE;
  logic       fwd_aD, fwd_bD;
  logic [1:0] fwd_aE, fwd_bE;
  logic       hilo_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int since_md = 1000;
  int m_sc = 0;
  int m_fe = 0;
  bit e_stall, e_flushD;

  hazard_unit #(.MDU_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .write_regE(write_regE), .write_regM(write_regM),
    .write_regW(write_regW),
    .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
    .dm2_regE(dm2_regE), .dm2_regM(dm2_regM),
    .branchD(branchD), .pc_srcD(pc_srcD), .jumpD(jumpD),
    .hi_loE(hi_loE), .mf_hi_loD(mf_hi_loD),
    .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE),
    .fwd_aD(fwd_aD), .fwd_bD(fwd_bD),
    .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
    .hilo_busy(hilo_busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp_v);
    end
  endtask

  function automatic bit dep(input logic [4:0] w,
                             input logic [4:0] r);
    return (w != 0) && (w == r);
  endfunction

  function automatic int fw(input logic [4:0] r);
    if (we_regM && dep(write_regM, r)) return 2;
    if (we_regW && dep(write_regW, r)) return 1;
    return 0;
  endfunction

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    write_regE = 0; write_regM = 0; write_regW = 0;
    we_regE = 0; we_regM = 0; we_regW = 0;
    dm2_regE = 0; dm2_regM = 0;
    branchD = 0; pc_srcD = 0; jumpD = 0;
    hi_loE = 0; mf_hi_loD = 0;
  endtask

  // mid-cycle: compare every output with the model
  task automatic settle();
    bit lw, br, md, busy;
    int ea, eb, ead, ebd;
    #4;
    busy = (since_md >= 1) && (since_md <= LAT);
    lw = dm2_regE &&
      (dep(write_regE, rsD) || dep(write_regE, rtD));
    br = branchD &&
      ((we_regE &&
        (dep(write_regE, rsD) || dep(write_regE, rtD))) ||
       (dm2_regM &&
        (dep(write_regM, rsD) || dep(write_regM, rtD))));
    md = mf_hi_loD && (busy || hi_loE);
    e_stall  = !rst && (lw || br || md);
    e_flushD = !rst && (pc_srcD || jumpD) && !e_stall;
    ea  = rst ? 0 : fw(rsE);
    eb  = rst ? 0 : fw(rtE);
    ead = (!rst && we_regM && dep(write_regM, rsD)) ? 1 : 0;
    ebd = (!rst && we_regM && dep(write_regM, rtD)) ? 1 : 0;
    chk("stallF", 32'(stallF), 32'(e_stall));
    chk("stallD", 32'(stallD), 32'(e_stall));
    chk("flushE", 32'(flushE), 32'(e_stall));
    chk("flushD", 32'(flushD), 32'(e_flushD));
    chk("fwd_aE", 32'(fwd_aE), ea);
    chk("fwd_bE", 32'(fwd_bE), eb);
    chk("fwd_aD", 32'(fwd_aD), ead);
    chk("fwd_bD", 32'(fwd_bD), ebd);
    chk("hilo_busy", 32'(hilo_busy), 32'(busy));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_events", flush_events, m_fe);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      since_md = 1000;
      m_sc = 0;
      m_fe = 0;
    end else begin
      if (hi_loE) since_md = 1;
      else if (since_md < 1000) since_md++;
      if (e_stall) m_sc++;
      if (e_flushD) m_fe++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  initial begin
    clr();
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("reset_busy", 32'(hilo_busy), 0);
    tick();

    // load-use stall, then forwarding from MEM / WB
    dm2_regE = 1; we_regE = 1; write_regE = 2; rsD = 2;
    settle();
    chk("lw_stall", 32'(stallF), 1);
    tick();
    clr();
    we_regM = 1; dm2_regM = 1; write_regM = 2; rsE = 2;
    settle();
    tick();
    clr();
    we_regW = 1; write_regW = 2; rsE = 2;
    settle();
    chk("lw_fwd_wb", 32'(fwd_aE), 1);
    chk("lw_nostall", 32'(stallD), 0);
    tick();

    // MEM over WB priority; $0 never forwards
    clr();
    we_regM = 1; write_regM = 5;
    we_regW = 1; write_regW = 5; rsE = 5; rtE = 5;
    settle();
    chk("fwd_prio", 32'(fwd_aE), 2);
    tick();
    write_regM = 0; write_regW = 0; rsE = 0; rtE = 0;
    settle();
    chk("fwd_r0", 32'(fwd_aE), 0);
    tick();

    // branch on an EX result, then resolved from MEM
    clr();
    branchD = 1; rsD = 3; we_regE = 1; write_regE = 3;
    settle();
    chk("br_stall", 32'(stallD), 1);
    tick();
    clr();
    branchD = 1; rsD = 3; we_regM = 1; write_regM = 3;
    settle();
    chk("br_go", 32'(stallD), 0);
    chk("br_fwd", 32'(fwd_aD), 1);
    tick();

    // single mult then mfhi
    clr();
    hi_loE = 1;
    settle();
    tick();
    hi_loE = 0; mf_hi_loD = 1;
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk("md_busy", 32'(hilo_busy), 32'(k <= LAT));
      chk("md_stall", 32'(stallF), 32'(k <= LAT));
      tick();
    end

    // second op at cycle 2 extends the window
    idle(6);
    hi_loE = 1; mf_hi_loD = 1;
    settle();
    chk("md_same", 32'(stallF), 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      hi_loE = (k == 2);
      settle();
      chk("md_ext", 32'(hilo_busy), 32'(k <= LAT + 2));
      tick();
    end

    // taken branch alone, then with a load-use hazard
    clr();
    pc_srcD = 1;
    settle();
    chk("flush_br", 32'(flushD), 1);
    chk("flush_nost", 32'(stallF), 0);
    tick();
    dm2_regE = 1; write_regE = 7; rtD = 7;
    settle();
    chk("flush_lw", 32'(flushD), 0);
    chk("stall_lw", 32'(flushE), 1);
    tick();

    // reset in the middle of an MDU window
    clr();
    hi_loE = 1;
    settle();
    tick();
    hi_loE = 0;
    settle();
    tick();
    rst = 1;
    dm2_regE = 1; write_regE = 4; rsD = 4;
    pc_srcD = 1; we_regM = 1; write_regM = 4; rsE = 4;
    settle();
    chk("rst_stall", 32'(stallF), 0);
    chk("rst_flush", 32'(flushD), 0);
    chk("rst_fwd", 32'(fwd_aE), 0);
    tick();
    rst = 0;
    clr();
    settle();
    chk("rst_busy", 32'(hilo_busy), 0);
`ifdef HAZARD_PERF_EN
    chk("perf_rst", stall_cycles, 0);
`endif
    tick();
    dm2_regE = 1; write_regE = 9; rsD = 9;
    for (int k = 0; k < 3; k++) begin
      settle();
      tick();
    end
    clr();
    settle();
`ifdef HAZARD_PERF_EN
    chk("perf_3", stall_cycles, 3);
`endif
    tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      rsD = 5'($urandom_range(0, 3));
      rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3));
      rtE = 5'($urandom_range(0, 3));
      write_regE = 5'($urandom_range(0, 3));
      write_regM = 5'($urandom_range(0, 3));
      write_regW = 5'($urandom_range(0, 3));
      we_regE  = 1'($urandom);
      we_regM  = 1'($urandom);
      we_regW  = 1'($urandom);
      dm2_regE = 1'($urandom);
      dm2_regM = 1'($urandom);
      branchD  = 1'($urandom);
      pc_srcD  = 1'($urandom);
      jumpD    = ($urandom_range(0, 3) == 0);
      hi_loE   = ($urandom_range(0, 5) == 0);
      mf_hi_loD = ($urandom_range(0, 2) == 0);
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
